// File: rtl/mpf_vtp_page_split_pkg.sv
// Shared helpers for the VTP write-channel page splitter: beat classification
// and the page arithmetic used to size each page-contained piece.
package mpf_vtp_page_split_pkg;

  // What an accepted input beat does to the outgoing command fields.
  typedef enum logic [1:0] {
    BEAT_HOLD  = 2'd0,  // continue the current piece, only data changes
    BEAT_SOP   = 2'd1,  // first beat of a source burst
    BEAT_PIECE = 2'd2   // first beat of a follow-on piece in the next page
  } t_beat_kind;

  // Number of cache lines in one translation page.
  function automatic int page_lines(input int page_size, input int line_bytes);
    return page_size / line_bytes;
  endfunction

  // Length of the piece starting at line offset 'off' within a page when
  // 'rem' lines are still to be sent: stop at whichever comes first.
  function automatic logic [31:0] piece_len(input logic [31:0] rem,
                                            input logic [31:0] off,
                                            input logic [31:0] pg_lines);
    logic [31:0] room;
    room = pg_lines - off;
    return (rem < room) ? rem : room;
  endfunction

endpackage

// File: rtl/mpf_vtp_avalon_wr_page_split.sv
// Avalon write-channel splitter: cuts any burst that crosses a PAGE_SIZE page
// into page-contained pieces so the downstream VTP stage translates exactly
// once per presented burst. All pieces but the last carry NO_REPLY so the
// source still sees one write response per original burst.
module mpf_vtp_avalon_wr_page_split
  import mpf_vtp_page_split_pkg::*;
#(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 8,
  parameter int PAGE_SIZE       = 4096,
  parameter int UFLAG_NO_REPLY  = 0,
  parameter int UFLAG_FENCE     = 1,
  parameter int UFLAG_INTERRUPT = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       in_write,
  output logic                       in_waitrequest,
  input  logic [ADDR_WIDTH-1:0]      in_address,
  input  logic [BURST_CNT_WIDTH-1:0] in_burstcount,
  input  logic [DATA_WIDTH-1:0]      in_writedata,
  input  logic [DATA_WIDTH/8-1:0]    in_byteenable,
  input  logic [USER_WIDTH-1:0]      in_user,

  output logic                       out_write,
  input  logic                       out_waitrequest,
  output logic [ADDR_WIDTH-1:0]      out_address,
  output logic [BURST_CNT_WIDTH-1:0] out_burstcount,
  output logic [DATA_WIDTH-1:0]      out_writedata,
  output logic [DATA_WIDTH/8-1:0]    out_byteenable,
  output logic [USER_WIDTH-1:0]      out_user,

  output logic [31:0]                split_count
);

  localparam int LINE_BYTES = DATA_WIDTH / 8;
  localparam int PAGE_LINES = page_lines(PAGE_SIZE, LINE_BYTES);
  localparam int OFF_W      = $clog2(PAGE_LINES);
  localparam int BC_W       = BURST_CNT_WIDTH;

  localparam logic [BC_W-1:0]       BC_ONE    = BC_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PAGE_STEP = ADDR_WIDTH'(PAGE_LINES);

  // Burst tracking carried between beats.
  typedef struct packed {
    logic                  in_burst;   // 0: next accepted beat is a source SOP
    logic [BC_W-1:0]       in_rem;     // source beats still to come
    logic [BC_W-1:0]       piece_rem;  // beats left in the current piece
    logic [ADDR_WIDTH-1:0] next_addr;  // line address of the next page
    logic [USER_WIDTH-1:0] sop_user;   // user flags latched at SOP
  } t_page_split_state;

  t_page_split_state state_q, state_d;

  logic                  out_write_q,      out_write_d;
  logic [ADDR_WIDTH-1:0] out_address_q,    out_address_d;
  logic [BC_W-1:0]       out_burstcount_q, out_burstcount_d;
  logic [DATA_WIDTH-1:0] out_writedata_q,  out_writedata_d;
  logic [LINE_BYTES-1:0] out_byteenable_q, out_byteenable_d;
  logic [USER_WIDTH-1:0] out_user_q,       out_user_d;
  logic [31:0]           split_count_q,    split_count_d;

  logic                  accept;
  t_beat_kind            beat_kind;
  logic [OFF_W-1:0]      sop_off;
  logic                  sop_nosplit;
  logic [BC_W:0]         sop_first;
  logic [ADDR_WIDTH-1:0] sop_page_next;
  logic [BC_W-1:0]       piece_new_len;
  logic                  piece_more;

  // Single output register: the source stalls only while a held beat stalls.
  assign in_waitrequest = out_write_q && out_waitrequest;
  assign accept         = in_write && !in_waitrequest;

  // SOP sizing: fences and interrupts are never split so their ordering
  // semantics stay attached to one command.
  assign sop_off       = in_address[OFF_W-1:0];
  assign sop_nosplit   = in_user[UFLAG_FENCE] | in_user[UFLAG_INTERRUPT];
  assign sop_first     = sop_nosplit ? {1'b0, in_burstcount}
                       : (BC_W+1)'(piece_len(32'(in_burstcount), 32'(sop_off),
                                             32'(PAGE_LINES)));
  assign sop_page_next = {in_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} + PAGE_STEP;

  // Follow-on pieces always start page-aligned.
  assign piece_new_len = BC_W'(piece_len(32'(state_q.in_rem), 32'd0, 32'(PAGE_LINES)));
  assign piece_more    = 32'(state_q.in_rem) > 32'(PAGE_LINES);

  // Classify the beat currently presented by the source.
  always_comb begin
    if (!state_q.in_burst) begin
      beat_kind = BEAT_SOP;
    end else if (state_q.piece_rem == '0) begin
      beat_kind = BEAT_PIECE;
    end else begin
      beat_kind = BEAT_HOLD;
    end
  end

  // Next-state for burst tracking and the output register.
  always_comb begin
    state_d          = state_q;
    out_write_d      = out_write_q;
    out_address_d    = out_address_q;
    out_burstcount_d = out_burstcount_q;
    out_writedata_d  = out_writedata_q;
    out_byteenable_d = out_byteenable_q;
    out_user_d       = out_user_q;
    split_count_d    = split_count_q;

    if (out_write_q && !out_waitrequest) begin
      out_write_d = 1'b0;
    end

    if (accept) begin
      out_write_d       = 1'b1;
      out_writedata_d   = in_writedata;
      out_byteenable_d  = in_byteenable;
      state_d.in_rem    = state_q.in_rem - BC_ONE;
      state_d.piece_rem = state_q.piece_rem - BC_ONE;
      state_d.in_burst  = (state_q.in_rem != BC_ONE);

      case (beat_kind)
        BEAT_SOP: begin
          out_address_d    = in_address;
          out_burstcount_d = sop_first[BC_W-1:0];
          out_user_d       = in_user;
          if (sop_first < {1'b0, in_burstcount}) begin
            out_user_d[UFLAG_NO_REPLY] = 1'b1;
          end
          state_d.in_rem    = in_burstcount - BC_ONE;
          state_d.piece_rem = sop_first[BC_W-1:0] - BC_ONE;
          state_d.next_addr = sop_page_next;
          state_d.sop_user  = in_user;
          state_d.in_burst  = (in_burstcount != BC_ONE);
        end
        BEAT_PIECE: begin
          out_address_d    = state_q.next_addr;
          out_burstcount_d = piece_new_len;
          out_user_d       = state_q.sop_user;
          if (piece_more) begin
            out_user_d[UFLAG_NO_REPLY] = 1'b1;
          end
          state_d.next_addr = state_q.next_addr + PAGE_STEP;
          state_d.piece_rem = piece_new_len - BC_ONE;
          split_count_d     = (split_count_q == '1) ? split_count_q
                                                    : split_count_q + 32'd1;
        end
        default: begin
          // Mid-piece beat: command fields keep the piece's values.
        end
      endcase
    end
  end

  // State and output registers; reset drops any partial burst and held beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= '0;
      out_write_q      <= 1'b0;
      out_address_q    <= '0;
      out_burstcount_q <= '0;
      out_writedata_q  <= '0;
      out_byteenable_q <= '0;
      out_user_q       <= '0;
      split_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      out_write_q      <= out_write_d;
      out_address_q    <= out_address_d;
      out_burstcount_q <= out_burstcount_d;
      out_writedata_q  <= out_writedata_d;
      out_byteenable_q <= out_byteenable_d;
      out_user_q       <= out_user_d;
      split_count_q    <= split_count_d;
    end
  end

  assign out_write      = out_write_q;
  assign out_address    = out_address_q;
  assign out_burstcount = out_burstcount_q;
  assign out_writedata  = out_writedata_q;
  assign out_byteenable = out_byteenable_q;
  assign out_user       = out_user_q;
  assign split_count    = split_count_q;

  // A zero-length burst would wrap the beat counters; flag it in simulation.
  a_burstcount_nonzero: assert property (
    @(posedge clk) disable iff (!reset_n)
      (accept && !state_q.in_burst) |-> (in_burstcount != '0)
  ) else $fatal(1, "burstcount 0 accepted at SOP");

endmodule
